// File: rtl/vram_write_arbiter_if.sv
// Requester handshakes, window/clear controls and the registered VRAM write port
// of vram_write_arbiter, with arbiter-side (slave) and driver-side (master) views.
interface vram_write_arbiter_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 10
);
    logic              vBlank;
    logic              clearStart;
    logic              r0Valid;
    logic [ADDR_W-1:0] r0Addr;
    logic [DATA_W-1:0] r0Data;
    logic              r0Ready;
    logic              r1Valid;
    logic [ADDR_W-1:0] r1Addr;
    logic [DATA_W-1:0] r1Data;
    logic              r1Ready;
    logic              vramWriteEn;
    logic [ADDR_W-1:0] vramWriteAddr;
    logic [DATA_W-1:0] vramInData;
    logic [1:0]        grantId;
    logic              clearBusy;
    logic              addrErr;

    modport slave (
        input  vBlank, clearStart,
        input  r0Valid, r0Addr, r0Data,
        output r0Ready,
        input  r1Valid, r1Addr, r1Data,
        output r1Ready,
        output vramWriteEn, vramWriteAddr, vramInData, grantId, clearBusy, addrErr
    );

    modport master (
        output vBlank, clearStart,
        output r0Valid, r0Addr, r0Data,
        input  r0Ready,
        output r1Valid, r1Addr, r1Data,
        input  r1Ready,
        input  vramWriteEn, vramWriteAddr, vramInData, grantId, clearBusy, addrErr
    );
endinterface

// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter for the VGAGenerator VRAM write port with a built-in
// full-memory clear sequencer and optional vertical-blanking write gating.
module vram_write_arbiter #(
    parameter int unsigned       ADDR_W      = 10,
    parameter int unsigned       DATA_W      = 10,
    parameter int unsigned       DEPTH       = 1024,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0,
    parameter bit                GATE_VBLANK = 1'b1
) (
    input  logic                inClock,
    input  logic                reset,
    vram_write_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] clear_cnt;
    logic              last_grant;  // 1 = r1 was granted last, so r0 wins the next tie
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        grant_id;
    logic              busy;
    logic              addr_err;

    logic win;
    logic accept_open;
    logic take0;
    logic take1;
    logic in_range0;
    logic in_range1;

    // Readies are combinational; clearStart and reset both block any transfer.
    always_comb begin
        win         = !GATE_VBLANK || bus.vBlank;
        accept_open = (state == IDLE) && win && !bus.clearStart && !reset;
        take0       = accept_open && bus.r0Valid && (!bus.r1Valid || last_grant);
        take1       = accept_open && bus.r1Valid && (!bus.r0Valid || !last_grant);
        in_range0   = 32'(bus.r0Addr) < DEPTH;
        in_range1   = 32'(bus.r1Addr) < DEPTH;
    end

    always_ff @(posedge inClock) begin
        if (reset) begin
            state      <= IDLE;
            clear_cnt  <= '0;
            last_grant <= 1'b1;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            addr_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.clearStart) begin
                        state     <= CLEAR;
                        clear_cnt <= '0;
                        busy      <= 1'b1;
                    end else if (take0) begin
                        last_grant <= 1'b0;
                        if (in_range0) begin
                            wr_en    <= 1'b1;
                            wr_addr  <= bus.r0Addr;
                            wr_data  <= bus.r0Data;
                            grant_id <= 2'd0;
                        end else begin
                            addr_err <= 1'b1;
                        end
                    end else if (take1) begin
                        last_grant <= 1'b1;
                        if (in_range1) begin
                            wr_en    <= 1'b1;
                            wr_addr  <= bus.r1Addr;
                            wr_data  <= bus.r1Data;
                            grant_id <= 2'd1;
                        end else begin
                            addr_err <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (win) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= clear_cnt;
                        wr_data  <= CLEAR_VALUE;
                        grant_id <= 2'd2;
                        if (clear_cnt == LAST_ADDR) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            clear_cnt <= '0;
                        end else begin
                            clear_cnt <= clear_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.r0Ready       = take0;
    assign bus.r1Ready       = take1;
    assign bus.vramWriteEn   = wr_en;
    assign bus.vramWriteAddr = wr_addr;
    assign bus.vramInData    = wr_data;
    assign bus.grantId       = grant_id;
    assign bus.clearBusy     = busy;
    assign bus.addrErr       = addr_err;
endmodule

// File: tb/tb_vram_write_arbiter.sv
// Drives two arbiter instances (gated DEPTH=1024, ungated DEPTH=1000) with
// directed and random traffic and compares every cycle against a reference model.
module tb_vram_write_arbiter;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 10;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Per-instance configuration: index 0 = dut_a, 1 = dut_b
    int unsigned depth [2] = '{1024, 1000};
    bit          gated [2] = '{1'b1, 1'b0};
    int unsigned cval  [2] = '{0, 'h155};

    // Driven inputs
    logic          i_rst [2];
    logic          i_vb  [2];
    logic          i_cs  [2];
    logic          i_v   [2][2];
    logic [AW-1:0] i_a   [2][2];
    logic [DW-1:0] i_d   [2][2];
    bit            acc   [2][2];

    // Observed outputs
    logic          o_rdy  [2][2];
    logic          o_en   [2];
    logic [AW-1:0] o_addr [2];
    logic [DW-1:0] o_data [2];
    logic [1:0]    o_gid  [2];
    logic          o_busy [2];
    logic          o_err  [2];

    // Scenario controls shared by both instances
    bit            ctl_rst, ctl_vb, ctl_cs;
    bit            offer_v [2];
    logic [AW-1:0] offer_a [2];
    logic [DW-1:0] offer_d [2];

    // Reference model state
    bit          m_clr  [2];
    int unsigned m_cnt  [2];
    int unsigned m_last [2];
    bit          m_en   [2];
    int unsigned m_addr [2];
    int unsigned m_data [2];
    int unsigned m_gid  [2];
    bit          m_busy [2];
    bit          m_err  [2];
    bit          e_rdy  [2][2];

    int unsigned clr_seen [2];

    vram_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    vram_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

    vram_write_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(1024), .CLEAR_VALUE(10'h000), .GATE_VBLANK(1'b1)
    ) dut_a (
        .inClock(clk), .reset(i_rst[0]), .bus(ifa)
    );

    vram_write_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(1000), .CLEAR_VALUE(10'h155), .GATE_VBLANK(1'b0)
    ) dut_b (
        .inClock(clk), .reset(i_rst[1]), .bus(ifb)
    );

    assign ifa.vBlank = i_vb[0];
    assign ifa.clearStart = i_cs[0];
    assign ifa.r0Valid = i_v[0][0];
    assign ifa.r0Addr = i_a[0][0];
    assign ifa.r0Data = i_d[0][0];
    assign ifa.r1Valid = i_v[0][1];
    assign ifa.r1Addr = i_a[0][1];
    assign ifa.r1Data = i_d[0][1];
    assign ifb.vBlank = i_vb[1];
    assign ifb.clearStart = i_cs[1];
    assign ifb.r0Valid = i_v[1][0];
    assign ifb.r0Addr = i_a[1][0];
    assign ifb.r0Data = i_d[1][0];
    assign ifb.r1Valid = i_v[1][1];
    assign ifb.r1Addr = i_a[1][1];
    assign ifb.r1Data = i_d[1][1];

    assign o_rdy[0][0] = ifa.r0Ready;
    assign o_rdy[0][1] = ifa.r1Ready;
    assign o_en[0] = ifa.vramWriteEn;
    assign o_addr[0] = ifa.vramWriteAddr;
    assign o_data[0] = ifa.vramInData;
    assign o_gid[0] = ifa.grantId;
    assign o_busy[0] = ifa.clearBusy;
    assign o_err[0] = ifa.addrErr;
    assign o_rdy[1][0] = ifb.r0Ready;
    assign o_rdy[1][1] = ifb.r1Ready;
    assign o_en[1] = ifb.vramWriteEn;
    assign o_addr[1] = ifb.vramWriteAddr;
    assign o_data[1] = ifb.vramInData;
    assign o_gid[1] = ifb.grantId;
    assign o_busy[1] = ifb.clearBusy;
    assign o_err[1] = ifb.addrErr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Who should be accepted this cycle, from the arbitration rules
    task automatic model_ready(input int unsigned k);
        bit win;
        win = !gated[k] || i_vb[k];
        e_rdy[k][0] = 1'b0;
        e_rdy[k][1] = 1'b0;
        if (!i_rst[k] && !m_clr[k] && win && !i_cs[k]) begin
            if (i_v[k][0] && i_v[k][1])
                e_rdy[k][(m_last[k] == 0) ? 1 : 0] = 1'b1;
            else if (i_v[k][0])
                e_rdy[k][0] = 1'b1;
            else if (i_v[k][1])
                e_rdy[k][1] = 1'b1;
        end
    endtask

    // What the clock edge does to the write port, clear progress and fairness
    task automatic model_edge(input int unsigned k);
        bit win;
        win = !gated[k] || i_vb[k];
        if (i_rst[k]) begin
            m_clr[k] = 0; m_cnt[k] = 0; m_last[k] = 1;
            m_en[k] = 0; m_addr[k] = 0; m_data[k] = 0; m_gid[k] = 0;
            m_busy[k] = 0; m_err[k] = 0;
        end else begin
            m_en[k] = 0;
            m_err[k] = 0;
            if (!m_clr[k]) begin
                if (i_cs[k]) begin
                    m_clr[k] = 1; m_cnt[k] = 0; m_busy[k] = 1;
                end else begin
                    for (int unsigned n = 0; n < 2; n++) begin
                        if (e_rdy[k][n]) begin
                            m_last[k] = n;
                            if (i_a[k][n] < depth[k]) begin
                                m_en[k] = 1; m_addr[k] = i_a[k][n];
                                m_data[k] = i_d[k][n]; m_gid[k] = n;
                            end else begin
                                m_err[k] = 1;
                            end
                        end
                    end
                end
            end else if (win) begin
                m_en[k] = 1; m_addr[k] = m_cnt[k]; m_data[k] = cval[k]; m_gid[k] = 2;
                m_cnt[k]++;
                if (m_cnt[k] == depth[k]) begin
                    m_clr[k] = 0; m_busy[k] = 0; m_cnt[k] = 0;
                end
            end
        end
    endtask

    task automatic check_dut(input int unsigned k);
        string p;
        p = (k == 0) ? "A" : "B";
        check({p, ".r0Ready"}, 32'(o_rdy[k][0]), 32'(e_rdy[k][0]));
        check({p, ".r1Ready"}, 32'(o_rdy[k][1]), 32'(e_rdy[k][1]));
        check({p, ".vramWriteEn"}, 32'(o_en[k]), 32'(m_en[k]));
        check({p, ".vramWriteAddr"}, 32'(o_addr[k]), m_addr[k]);
        check({p, ".vramInData"}, 32'(o_data[k]), m_data[k]);
        check({p, ".clearBusy"}, 32'(o_busy[k]), 32'(m_busy[k]));
        check({p, ".addrErr"}, 32'(o_err[k]), 32'(m_err[k]));
        if (m_en[k])
            check({p, ".grantId"}, 32'(o_gid[k]), m_gid[k]);
    endtask

    // One clock: apply inputs (pending requests stay stable), check, advance model
    task automatic run_cycle();
        for (int unsigned k = 0; k < 2; k++) begin
            i_rst[k] = ctl_rst;
            i_vb[k]  = ctl_vb;
            i_cs[k]  = ctl_cs;
            for (int unsigned n = 0; n < 2; n++) begin
                if (!(i_v[k][n] && !acc[k][n])) begin
                    i_v[k][n] = offer_v[n];
                    i_a[k][n] = offer_a[n];
                    i_d[k][n] = offer_d[n];
                end
            end
        end
        @(negedge clk);
        for (int unsigned k = 0; k < 2; k++) begin
            model_ready(k);
            check_dut(k);
            if (o_en[k] === 1'b1 && o_gid[k] === 2'd2)
                clr_seen[k]++;
        end
        @(posedge clk);
        for (int unsigned k = 0; k < 2; k++) begin
            model_edge(k);
            for (int unsigned n = 0; n < 2; n++)
                acc[k][n] = e_rdy[k][n];
        end
        #1;
    endtask

    task automatic run_clear();
        clr_seen[0] = 0;
        clr_seen[1] = 0;
        ctl_cs = 1;
        run_cycle();
        ctl_cs = 0;
        repeat (1030) run_cycle();
        check("A.clear_write_count", clr_seen[0], 1024);
        check("B.clear_write_count", clr_seen[1], 1000);
    endtask

    initial begin
        bit reached;
        ctl_rst = 1; ctl_vb = 0; ctl_cs = 0;
        for (int unsigned n = 0; n < 2; n++) begin
            offer_v[n] = 0; offer_a[n] = '0; offer_d[n] = '0;
        end
        for (int unsigned k = 0; k < 2; k++) begin
            i_rst[k] = 1; i_vb[k] = 0; i_cs[k] = 0;
            for (int unsigned n = 0; n < 2; n++) begin
                i_v[k][n] = 0; i_a[k][n] = '0; i_d[k][n] = '0; acc[k][n] = 0; e_rdy[k][n] = 0;
            end
        end
        @(posedge clk);
        for (int unsigned k = 0; k < 2; k++) model_edge(k);
        #1;
        run_cycle();
        ctl_rst = 0;
        ctl_vb = 1;

        // Single r0 write
        offer_v[0] = 1; offer_a[0] = 10'd5; offer_d[0] = 10'h3A;
        run_cycle();
        offer_v[0] = 0;
        run_cycle();

        // Both requesters contending for four cycles
        offer_v[0] = 1; offer_v[1] = 1; offer_a[0] = 10'd7; offer_a[1] = 10'd9;
        for (int unsigned i = 0; i < 4; i++) begin
            offer_d[0] = DW'(i + 16);
            offer_d[1] = DW'(i + 32);
            run_cycle();
        end
        offer_v[0] = 0; offer_v[1] = 0;
        repeat (2) run_cycle();

        // r1 waiting outside the window, then released
        ctl_vb = 0;
        offer_v[1] = 1; offer_a[1] = 10'd12; offer_d[1] = 10'h2F;
        repeat (10) run_cycle();
        offer_v[1] = 0;
        ctl_vb = 1;
        repeat (2) run_cycle();

        // Address beyond DEPTH for dut_b, legal for dut_a
        offer_v[0] = 1; offer_a[0] = 10'd1010; offer_d[0] = 10'h07;
        run_cycle();
        offer_v[0] = 0;
        repeat (2) run_cycle();

        // Full clear with r0 pending throughout
        offer_v[0] = 1; offer_a[0] = 10'd44; offer_d[0] = 10'h1C1;
        run_clear();
        offer_v[0] = 0;
        repeat (4) run_cycle();

        // Clear under a toggling window, aborted by reset at address 300
        ctl_cs = 1;
        run_cycle();
        ctl_cs = 0;
        reached = 0;
        for (int unsigned i = 0; i < 2000 && !reached; i++) begin
            ctl_vb = !ctl_vb;
            run_cycle();
            reached = m_clr[0] && (m_cnt[0] == 300);
        end
        check("A.clear_reached_300", 32'(reached), 32'd1);
        ctl_rst = 1;
        run_cycle();
        ctl_rst = 0;
        ctl_vb = 1;
        repeat (2) run_cycle();
        run_clear();

        // Random traffic
        repeat (4000) begin
            ctl_vb  = ($urandom_range(0, 1) == 1);
            ctl_cs  = ($urandom_range(0, 499) == 0);
            ctl_rst = ($urandom_range(0, 1999) == 0);
            for (int unsigned n = 0; n < 2; n++) begin
                offer_v[n] = ($urandom_range(0, 9) < 6);
                offer_a[n] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(990, 1023))
                                                         : AW'($urandom_range(0, 1023));
                offer_d[n] = DW'($urandom);
            end
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vram_write_arbiter.md
Name: vram_write_arbiter

Overview:
- Schedules all writes into the VGAGenerator video RAM write port (vramWriteAddr/vramInData plus a write enable).
- Shares the port between two streaming requesters: req0 is the FFT/sample stream, req1 is the game/overlay writer.
- Contains a built-in clear sequencer that fills the whole VRAM with a constant.
- Can restrict all writes to vertical blanking so the displayed frame never tears.

Parameters:
- ADDR_W, 10, VRAM address width.
- DATA_W, 10, VRAM word width.
- DEPTH, 1024, number of valid VRAM words; addresses 0..DEPTH-1.
- CLEAR_VALUE, 0, word written by the clear sequencer.
- GATE_VBLANK, 1, 1 = writes only while vBlank=1; 0 = writes any cycle.

Ports:
- inClock  in  1  system clock (50 MHz domain, same as vramWriteClock).
- reset  in  1  synchronous, active-high reset.
- vBlank  in  1  high during vertical blanking, synchronous to inClock.
- clearStart  in  1  one-cycle pulse that starts a full-VRAM clear.
- r0Valid  in  1  requester 0 has a write.
- r0Addr  in  ADDR_W  requester 0 address.
- r0Data  in  DATA_W  requester 0 data.
- r0Ready  out  1  requester 0 transfer accepted this cycle.
- r1Valid  in  1  requester 1 has a write.
- r1Addr  in  ADDR_W  requester 1 address.
- r1Data  in  DATA_W  requester 1 data.
- r1Ready  out  1  requester 1 transfer accepted this cycle.
- vramWriteEn  out  1  registered write strobe to the VRAM.
- vramWriteAddr  out  ADDR_W  registered write address.
- vramInData  out  DATA_W  registered write data.
- grantId  out  2  source of the current write: 0 = r0, 1 = r1, 2 = clear. Valid when vramWriteEn=1.
- clearBusy  out  1  clear sequence in progress.
- addrErr  out  1  one-cycle pulse: an accepted request had address ≥ DEPTH.

Behaviour:
- Reset (synchronous, reset=1 at an inClock edge) forces every output to 0: vramWriteEn, vramWriteAddr, vramInData, grantId, clearBusy, addrErr, r0Ready, r1Ready.
- Reset also sets FSM=IDLE, clear counter=0, and the round-robin pointer lastGrant=1, so r0 wins the first tie.
- Reset mid-clear abandons the clear. No write occurs on the reset cycle.
- Write window: win = (GATE_VBLANK==0) | vBlank. No transfer and no clear step happens when win=0.

FSM states:
- IDLE:
  - clearStart=1 → CLEAR, counter=0, clearBusy=1 from the next cycle.
  - Otherwise, arbitrate requesters when win=1.
- CLEAR:
  - Each cycle with win=1, issue a write at addr=counter with data=CLEAR_VALUE and grantId=2, then counter++.
  - After issuing addr DEPTH-1 → IDLE, with clearBusy=0 on the following cycle.
  - Requester readies are held at 0 throughout CLEAR.
  - clearStart during CLEAR is ignored; it does not restart the sequence.

Arbitration (IDLE only):
- rNReady is combinational and asserted only for the granted requester, only when win=1.
- A transfer occurs when rNValid & rNReady.
- Only one valid → grant it.
- Both valid → grant the requester other than lastGrant.
- lastGrant updates only on an actual transfer.
- Ready may assert while valid=0 is not allowed: ready=0 whenever the requester's valid=0.
- Requesters hold addr/data stable while valid=1 and not ready.
- clearStart and a requester valid in the same IDLE cycle: clear wins. No requester transfer that cycle; the FSM enters CLEAR.

Output timing:
- Latency is 1 cycle. A transfer or clear step at edge N appears on vramWriteEn/addr/data/grantId during cycle N+1.
- vramWriteEn=0 on cycles without a transfer or clear step. Addr/data then hold their last value.

Address errors:
- An accepted request with addr ≥ DEPTH (only possible if DEPTH < 2^ADDR_W) is consumed (ready=1).
- It produces vramWriteEn=0 and addrErr=1 with the same 1-cycle latency.

Wrap and throughput:
- The clear counter never exceeds DEPTH-1.
- Maximum throughput is one write per cycle.
- A full clear takes exactly DEPTH window cycles.

Test Plan:
- Reset then r0Valid=1, addr=5, data=0x3A, vBlank=1 → r0Ready=1 same cycle; next cycle vramWriteEn=1, addr=5, data=0x3A, grantId=0.
- r0Valid and r1Valid held at 1 for 4 cycles, vBlank=1 → grants alternate r0,r1,r0,r1; exactly 4 writes; neither requester starves.
- GATE_VBLANK=1, vBlank=0, r1Valid=1 for 10 cycles → r1Ready=0 and vramWriteEn=0 throughout. Raise vBlank → r1 accepted on the first window cycle.
- clearStart with DEPTH=1024, vBlank=1 constant → 1024 consecutive writes, addr 0..1023, data=CLEAR_VALUE, grantId=2; clearBusy high for 1024 cycles; r0Ready=0 during the clear even with r0Valid=1.
- Clear with vBlank toggling 1 cycle on / 1 cycle off → writes only in vBlank cycles; total still 1024 with addresses contiguous. Assert reset at address 300 → next cycle all outputs 0, FSM in IDLE, a later clear restarts at addr 0.
- DEPTH=1000, r0Addr=1010, vBlank=1 → r0Ready=1; next cycle addrErr=1 and vramWriteEn=0.
